// File: rtl/bram_loader.sv
// -----------------------------------------------------------------------------
// bram_loader
//
// Host-side write engine for one GAT accelerator input BRAM (H_col_idx,
// H_value, H_node_info, Weight or a). A valid/ready word stream is turned into
// port-A writes (din/ena/addra). After the requested number of words has been
// written, the level-sensitive load_done_o is raised. The compute pipeline ANDs
// this flag into its start condition.
//
// Optional feature macro: BRAM_LOADER_CHECKSUM_EN
//   When this macro is defined, every load carries one extra trailer word. The
//   trailer is compared against the XOR of all written words. A mismatch sets
//   the sticky chk_err_o. When the macro is undefined, the stream carries
//   exactly len words and chk_err_o is tied low.
//
// Parameters
//   DATA_W  BRAM word width
//   ADDR_W  BRAM address width
//   DEPTH   number of writable words; legal load lengths are 1..DEPTH
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle load request, honoured only in IDLE or DONE
//   len_i         number of data words, sampled with start_i
//   s_data_i      stream data
//   s_valid_i     stream valid
//   s_ready_o     stream ready (high while a load or trailer is expected)
//   bram_din_o    BRAM write data
//   bram_ena_o    BRAM write strobe, one cycle per written word
//   bram_addra_o  BRAM write address
//   load_done_o   level: memory fully loaded
//   busy_o        high while loading (LOAD or CHK)
//   len_err_o     one-cycle pulse: start rejected because of an illegal length
//   chk_err_o     sticky trailer checksum mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module bram_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] bram_din_o,
  output logic              bram_ena_o,
  output logic [ADDR_W-1:0] bram_addra_o,
  output logic              load_done_o,
  output logic              busy_o,
  output logic              len_err_o,
  output logic              chk_err_o
);

  // The length and word counter are one bit wider than the address. This lets
  // len == DEPTH be represented even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

`ifdef BRAM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_e;
`endif

  state_e state_q, state_d;

  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;

`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              chk_err_q, chk_err_d;
`endif

  logic              hs;
  logic              len_ok;
  logic [ADDR_W:0]   cnt_inc;

  // Next-state and output computation.
  // s_ready_o is the registered busy flag. A handshake therefore happens only
  // in LOAD/CHK, and the FSM never has to gate ready combinationally.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    ena_d     = 1'b0;
    addra_d   = addra_q;
    len_err_d = 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
    acc_d     = acc_q;
    chk_err_d = chk_err_q;
`endif

    hs      = busy_q & s_valid_i;
    len_ok  = (len_i != '0) && (len_i <= DEPTH_L);
    cnt_inc = cnt_q + ONE_L;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (len_ok) begin
            state_d = LOAD;
            len_d   = len_i;
            cnt_d   = '0;
            addra_d = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
            acc_d     = '0;
            chk_err_d = 1'b0;
`endif
          end else begin
            // A rejected start leaves the state unchanged. If the memory was
            // already loaded, load_done_o stays high.
            len_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        // The address is the count of words written so far. Because
        // len <= DEPTH was checked at start, the low ADDR_W bits never wrap.
        if (hs) begin
          ena_d   = 1'b1;
          din_d   = s_data_i;
          addra_d = cnt_q[ADDR_W-1:0];
          cnt_d   = cnt_inc;
`ifdef BRAM_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ s_data_i;
          if (cnt_inc == len_q) begin
            state_d = CHK;
          end
`else
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
`endif
        end
      end

`ifdef BRAM_LOADER_CHECKSUM_EN
      CHK: begin
        // The trailer is consumed but never written. acc_q already holds the
        // XOR of every written word, including the last one.
        if (hs) begin
          if (s_data_i != acc_q) begin
            chk_err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state. Each one changes
    // in the cycle after the edge that moves the FSM.
`ifdef BRAM_LOADER_CHECKSUM_EN
    busy_d = (state_d == LOAD) || (state_d == CHK);
`else
    busy_d = (state_d == LOAD);
`endif
    done_d = (state_d == DONE);
  end

  // State and output registers. An asynchronous reset abandons any transfer in
  // progress and returns the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      ena_q     <= 1'b0;
      addra_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
      acc_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      ena_q     <= ena_d;
      addra_q   <= addra_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
      acc_q     <= acc_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign s_ready_o    = busy_q;
  assign busy_o       = busy_q;
  assign bram_din_o   = din_q;
  assign bram_ena_o   = ena_q;
  assign bram_addra_o = addra_q;
  assign load_done_o  = done_q;
  assign len_err_o    = len_err_q;
`ifdef BRAM_LOADER_CHECKSUM_EN
  assign chk_err_o    = chk_err_q;
`else
  assign chk_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_loader
//
// Self-checking bench for bram_loader. It works with and without
// BRAM_LOADER_CHECKSUM_EN.
//
// The reference model describes a load at the transaction level:
//   - accepted words land at addresses 0..len-1, in order;
//   - each strobe appears in the cycle after its handshake;
//   - load_done_o rises in the cycle after the final accepted word (the last
//     data word or the trailer);
//   - the checksum flag is (trailer != XOR of the data).
// A monitor records what the DUT actually did, and each scenario task compares
// that record against the model.
// -----------------------------------------------------------------------------
module tb_bram_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   len_i = '0;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [DATA_W-1:0] bram_din_o;
  logic              bram_ena_o;
  logic [ADDR_W-1:0] bram_addra_o;
  logic              load_done_o;
  logic              busy_o;
  logic              len_err_o;
  logic              chk_err_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .bram_din_o   (bram_din_o),
    .bram_ena_o   (bram_ena_o),
    .bram_addra_o (bram_addra_o),
    .load_done_o  (load_done_o),
    .busy_o       (busy_o),
    .len_err_o    (len_err_o),
    .chk_err_o    (chk_err_o)
  );

  always #5 clk = ~clk;

  // Count rising edges. A value sampled on a falling edge is tagged with the
  // edge that produced it.
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: record every BRAM write and a few status statistics, all sampled
  // on the falling edge.
  logic [ADDR_W-1:0] act_addr[$];
  logic [DATA_W-1:0] act_data[$];
  int                act_cyc[$];
  int                busy_cnt, ready_cnt, len_err_cnt;
  int                done_rise_cyc, done_fall_cyc;
  logic              done_prev = 1'b0;
  logic              chk_at_rise = 1'b0;

  always @(negedge clk) begin
    if (bram_ena_o === 1'b1) begin
      act_addr.push_back(bram_addra_o);
      act_data.push_back(bram_din_o);
      act_cyc.push_back(cyc);
    end
    if (busy_o === 1'b1) busy_cnt++;
    if (s_ready_o === 1'b1) ready_cnt++;
    if (len_err_o === 1'b1) len_err_cnt++;
    if (load_done_o === 1'b1 && done_prev !== 1'b1) begin
      done_rise_cyc = cyc;
      chk_at_rise   = chk_err_o;
    end
    if (load_done_o === 1'b0 && done_prev === 1'b1) done_fall_cyc = cyc;
    done_prev = load_done_o;
  end

  task automatic clear_monitor();
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
    busy_cnt      = 0;
    ready_cnt     = 0;
    len_err_cnt   = 0;
    done_rise_cyc = -1;
    done_fall_cyc = -1;
  endtask

  // Stimulus description for run_load, plus the model results it produces.
  logic [DATA_W-1:0] stim_q[$];
  bit                vpat_q[$];
  int                valid_pct;
  int                mid_step;
  logic [ADDR_W:0]   mid_len;
  int                hs_cyc[$];
  int                start_cyc;
  bit                timed_out;
  logic [DATA_W-1:0] run_xor, run_trailer;
  logic              run_exp_chk;

  // Drive one complete load. The driver holds each word until it is accepted.
  // It also notes the edge of every handshake, so that strobe timing can be
  // checked against the model.
  task automatic run_load(input int len, input bit bad_en, input logic [DATA_W-1:0] bad_val);
    logic [DATA_W-1:0] words[$];
    int idx;
    int n;
    bit v;
    bit hs;
    words   = stim_q;
    run_xor = '0;
    foreach (stim_q[i]) run_xor ^= stim_q[i];
    run_trailer = bad_en ? bad_val : run_xor;
`ifdef BRAM_LOADER_CHECKSUM_EN
    words.push_back(run_trailer);
    run_exp_chk = (run_trailer != run_xor);
`else
    run_exp_chk = 1'b0;
`endif
    hs_cyc.delete();
    clear_monitor();
    @(negedge clk);
    start_i = 1'b1;
    len_i   = (ADDR_W+1)'(len);
    @(negedge clk);
    start_cyc = cyc;
    start_i   = 1'b0;
    idx = 0;
    n   = 0;
    while (idx < words.size() && n < 40 * len + 50) begin
      if (n < vpat_q.size()) v = vpat_q[n];
      else v = ($urandom_range(99) < valid_pct);
      s_valid_i = v;
      s_data_i  = v ? words[idx] : DATA_W'($urandom);
      if (n == mid_step) begin
        start_i = 1'b1;
        len_i   = mid_len;
      end else begin
        start_i = 1'b0;
      end
      hs = v && (s_ready_o === 1'b1);
      @(negedge clk);
      if (hs) begin
        hs_cyc.push_back(cyc);
        idx++;
      end
      n++;
    end
    s_valid_i = 1'b0;
    start_i   = 1'b0;
    timed_out = (idx < words.size());
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 0", s_ready_o); end
    n_cmp++; if (bram_din_o !== '0) begin n_err++; $display("[TB] FAIL reset_din: got %h want 0", bram_din_o); end
    n_cmp++; if (bram_ena_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ena: got %b want 0", bram_ena_o); end
    n_cmp++; if (bram_addra_o !== '0) begin n_err++; $display("[TB] FAIL reset_addra: got %h want 0", bram_addra_o); end
    n_cmp++; if (load_done_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", load_done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (len_err_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_len_err: got %b want 0", len_err_o); end
    n_cmp++; if (chk_err_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_chk_err: got %b want 0", chk_err_o); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (s_ready_o !== 1'b0 || load_done_o !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_idle: got ready=%b done=%b want 0/0", s_ready_o, load_done_o); end
  endtask

  task automatic test_illegal_len(input logic exp_done);
    int bad_lens[3];
    bad_lens[0] = 0;
    bad_lens[1] = DEPTH + 1;
    bad_lens[2] = (1 << (ADDR_W + 1)) - 1;
    clear_monitor();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_i = 1'b1;
      len_i   = (ADDR_W+1)'(bad_lens[i]);
      @(negedge clk);
      start_i = 1'b0;
      n_cmp++; if (len_err_o !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_pulse len=%0d: got %b want 1", bad_lens[i], len_err_o); end
      n_cmp++; if (load_done_o !== exp_done || s_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL illegal_state len=%0d: got done=%b ready=%b want %b/0", bad_lens[i], load_done_o, s_ready_o, exp_done); end
      @(negedge clk);
      n_cmp++; if (len_err_o !== 1'b0 || load_done_o !== exp_done) begin n_err++; $display("[TB] FAIL illegal_after len=%0d: got len_err=%b done=%b want 0/%b", bad_lens[i], len_err_o, load_done_o, exp_done); end
    end
    n_cmp++; if (act_addr.size() != 0) begin n_err++; $display("[TB] FAIL illegal_writes: got %0d writes want 0", act_addr.size()); end
    n_cmp++; if (len_err_cnt != 3) begin n_err++; $display("[TB] FAIL illegal_pulse_count: got %0d cycles want 3", len_err_cnt); end
  endtask

  task automatic test_continuous();
    int last;
    stim_q.delete();
    stim_q.push_back(16'h0011);
    stim_q.push_back(16'h0022);
    stim_q.push_back(16'h0033);
    stim_q.push_back(16'h0044);
    vpat_q.delete();
    valid_pct = 100;
    mid_step  = -1;
    run_load(4, 1'b0, '0);
    n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL cont_timeout: got %0d handshakes want all words", hs_cyc.size()); end
    n_cmp++; if (act_addr.size() != 4) begin n_err++; $display("[TB] FAIL cont_count: got %0d writes want 4", act_addr.size()); end
    for (int i = 0; i < act_addr.size() && i < 4; i++) begin
      n_cmp++; if (act_addr[i] !== ADDR_W'(i) || act_data[i] !== stim_q[i]) begin n_err++; $display("[TB] FAIL cont_word%0d: got addr=%0d data=%h want %0d/%h", i, act_addr[i], act_data[i], i, stim_q[i]); end
      if (i < hs_cyc.size()) begin
        n_cmp++; if (act_cyc[i] != hs_cyc[i]) begin n_err++; $display("[TB] FAIL cont_timing%0d: got strobe edge %0d want %0d", i, act_cyc[i], hs_cyc[i]); end
      end
    end
    n_cmp++; if (act_cyc.size() != 4 || act_cyc[3] - act_cyc[0] != 3) begin n_err++; $display("[TB] FAIL cont_consecutive: got %0d strobes not on 4 consecutive cycles want 4", act_cyc.size()); end
    last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -2;
    n_cmp++; if (done_rise_cyc != last) begin n_err++; $display("[TB] FAIL cont_done_edge: got %0d want %0d", done_rise_cyc, last); end
    n_cmp++; if (busy_cnt != last - start_cyc || ready_cnt != last - start_cyc) begin n_err++; $display("[TB] FAIL cont_busy_cycles: got busy=%0d ready=%0d want %0d", busy_cnt, ready_cnt, last - start_cyc); end
    n_cmp++; if (s_ready_o !== 1'b0 || busy_o !== 1'b0 || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL cont_after: got ready=%b busy=%b done=%b want 0/0/1", s_ready_o, busy_o, load_done_o); end
    n_cmp++; if (chk_at_rise !== run_exp_chk || chk_err_o !== run_exp_chk) begin n_err++; $display("[TB] FAIL cont_chk: got %b/%b want %b", chk_at_rise, chk_err_o, run_exp_chk); end
  endtask

  task automatic test_backpressure();
    int last;
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(DATA_W'($urandom));
    vpat_q.delete();
    vpat_q.push_back(1'b1); vpat_q.push_back(1'b0); vpat_q.push_back(1'b0);
    vpat_q.push_back(1'b1); vpat_q.push_back(1'b0); vpat_q.push_back(1'b1);
    valid_pct = 100;
    mid_step  = -1;
    run_load(3, 1'b0, '0);
    n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL bp_timeout: got %0d handshakes want all words", hs_cyc.size()); end
    n_cmp++; if (act_addr.size() != 3) begin n_err++; $display("[TB] FAIL bp_count: got %0d writes want 3", act_addr.size()); end
    for (int i = 0; i < act_addr.size() && i < 3 && i < hs_cyc.size(); i++) begin
      n_cmp++; if (act_addr[i] !== ADDR_W'(i) || act_data[i] !== stim_q[i] || act_cyc[i] != hs_cyc[i]) begin n_err++; $display("[TB] FAIL bp_word%0d: got addr=%0d data=%h edge=%0d want %0d/%h/%0d", i, act_addr[i], act_data[i], act_cyc[i], i, stim_q[i], hs_cyc[i]); end
    end
    n_cmp++; if (hs_cyc.size() < 3 || hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 2) begin n_err++; $display("[TB] FAIL bp_handshake_spacing: got %0d handshakes want spacing 3,2", hs_cyc.size()); end
    last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -2;
    n_cmp++; if (done_rise_cyc != last || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL bp_done: got edge %0d level %b want %0d/1", done_rise_cyc, load_done_o, last); end
    n_cmp++; if (ready_cnt != last - start_cyc) begin n_err++; $display("[TB] FAIL bp_ready_cycles: got %0d want %0d", ready_cnt, last - start_cyc); end
  endtask

  task automatic test_reload_ignored_start();
    int last;
    stim_q.delete();
    for (int i = 0; i < 2; i++) stim_q.push_back(DATA_W'($urandom));
    vpat_q.delete();
    valid_pct = 100;
    mid_step  = -1;
    run_load(2, 1'b0, '0);
    n_cmp++; if (act_addr.size() != 2 || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL reload_first: got %0d writes done=%b want 2/1", act_addr.size(), load_done_o); end
    stim_q.delete();
    for (int i = 0; i < 2; i++) stim_q.push_back(DATA_W'($urandom));
    vpat_q.push_back(1'b1); vpat_q.push_back(1'b0); vpat_q.push_back(1'b1);
    mid_step = 1;
    mid_len  = (ADDR_W+1)'(5);
    run_load(2, 1'b0, '0);
    n_cmp++; if (done_fall_cyc != start_cyc) begin n_err++; $display("[TB] FAIL reload_done_fall: got edge %0d want %0d", done_fall_cyc, start_cyc); end
    n_cmp++; if (act_addr.size() != 2) begin n_err++; $display("[TB] FAIL reload_count: got %0d writes want 2", act_addr.size()); end
    for (int i = 0; i < act_addr.size() && i < 2; i++) begin
      n_cmp++; if (act_addr[i] !== ADDR_W'(i) || act_data[i] !== stim_q[i]) begin n_err++; $display("[TB] FAIL reload_word%0d: got addr=%0d data=%h want %0d/%h", i, act_addr[i], act_data[i], i, stim_q[i]); end
    end
    n_cmp++; if (len_err_cnt != 0) begin n_err++; $display("[TB] FAIL reload_len_err: got %0d pulses want 0", len_err_cnt); end
    last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -2;
    n_cmp++; if (done_rise_cyc != last || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL reload_done: got edge %0d level %b want %0d/1", done_rise_cyc, load_done_o, last); end
  endtask

  task automatic test_reset_mid();
    clear_monitor();
    @(negedge clk);
    start_i = 1'b1;
    len_i   = (ADDR_W+1)'(8);
    @(negedge clk);
    start_i   = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = DATA_W'($urandom);
    @(negedge clk);
    s_data_i  = DATA_W'($urandom);
    @(negedge clk);
    rst_n     = 1'b0;
    s_valid_i = 1'b0;
    #1;
    n_cmp++; if ({s_ready_o, bram_ena_o, load_done_o, busy_o, len_err_o, chk_err_o} !== 6'b0) begin n_err++; $display("[TB] FAIL rstmid_flags: got ready=%b ena=%b done=%b busy=%b lerr=%b cerr=%b want all 0", s_ready_o, bram_ena_o, load_done_o, busy_o, len_err_o, chk_err_o); end
    n_cmp++; if (bram_din_o !== '0 || bram_addra_o !== '0) begin n_err++; $display("[TB] FAIL rstmid_bus: got din=%h addra=%h want 0/0", bram_din_o, bram_addra_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_monitor();
    s_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data_i = DATA_W'($urandom);
      @(negedge clk);
      n_cmp++; if (s_ready_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_idle%0d: got ready=%b busy=%b want 0/0", i, s_ready_o, busy_o); end
    end
    s_valid_i = 1'b0;
    n_cmp++; if (act_addr.size() != 0 || load_done_o !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_nowrite: got %0d writes done=%b want 0/0", act_addr.size(), load_done_o); end
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(DATA_W'($urandom));
    vpat_q.delete();
    valid_pct = 80;
    mid_step  = -1;
    run_load(8, 1'b0, '0);
    n_cmp++; if (timed_out || act_addr.size() != 8 || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_reload: got %0d writes done=%b want 8/1", act_addr.size(), load_done_o); end
    for (int i = 0; i < act_addr.size() && i < 8; i++) begin
      n_cmp++; if (act_addr[i] !== ADDR_W'(i) || act_data[i] !== stim_q[i]) begin n_err++; $display("[TB] FAIL rstmid_word%0d: got addr=%0d data=%h want %0d/%h", i, act_addr[i], act_data[i], i, stim_q[i]); end
    end
  endtask

  task automatic test_random_loads();
    int len;
    int last;
    for (int k = 0; k < 8; k++) begin
      len = (k == 0) ? 1 : (k == 1) ? DEPTH : $urandom_range(DEPTH, 1);
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(DATA_W'($urandom));
      vpat_q.delete();
      valid_pct = (k % 3 == 0) ? 100 : (k % 3 == 1) ? 70 : 35;
      mid_step  = $urandom_range(len, 0);
      mid_len   = (ADDR_W+1)'($urandom_range(DEPTH, 1));
      run_load(len, $urandom_range(1, 0) == 1, DATA_W'($urandom));
      n_cmp++; if (timed_out) begin n_err++; $display("[TB] FAIL rand%0d_timeout: got %0d handshakes want all words", k, hs_cyc.size()); end
      n_cmp++; if (act_addr.size() != len) begin n_err++; $display("[TB] FAIL rand%0d_count: got %0d writes want %0d", k, act_addr.size(), len); end
      for (int i = 0; i < act_addr.size() && i < len && i < hs_cyc.size(); i++) begin
        n_cmp++; if (act_addr[i] !== ADDR_W'(i) || act_data[i] !== stim_q[i] || act_cyc[i] != hs_cyc[i]) begin n_err++; $display("[TB] FAIL rand%0d_word%0d: got addr=%0d data=%h edge=%0d want %0d/%h/%0d", k, i, act_addr[i], act_data[i], act_cyc[i], i, stim_q[i], hs_cyc[i]); end
      end
      last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -2;
      n_cmp++; if (done_rise_cyc != last || load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL rand%0d_done: got edge %0d level %b want %0d/1", k, done_rise_cyc, load_done_o, last); end
      n_cmp++; if (busy_cnt != last - start_cyc || s_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL rand%0d_busy: got %0d cycles ready=%b want %0d/0", k, busy_cnt, s_ready_o, last - start_cyc); end
      n_cmp++; if (chk_at_rise !== run_exp_chk || chk_err_o !== run_exp_chk) begin n_err++; $display("[TB] FAIL rand%0d_chk: got %b/%b want %b", k, chk_at_rise, chk_err_o, run_exp_chk); end
      n_cmp++; if (len_err_cnt != 0) begin n_err++; $display("[TB] FAIL rand%0d_len_err: got %0d pulses want 0", k, len_err_cnt); end
    end
  endtask

`ifdef BRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      stim_q.delete();
      stim_q.push_back(16'h00F0);
      stim_q.push_back(16'h0F00);
      vpat_q.delete();
      valid_pct = 100;
      mid_step  = -1;
      run_load(2, pass == 1, 16'h0000);
      n_cmp++; if (run_trailer !== ((pass == 1) ? 16'h0000 : 16'h0FF0)) begin n_err++; $display("[TB] FAIL chk%0d_trailer: got %h want %h", pass, run_trailer, (pass == 1) ? 16'h0000 : 16'h0FF0); end
      n_cmp++; if (load_done_o !== 1'b1) begin n_err++; $display("[TB] FAIL chk%0d_done: got %b want 1", pass, load_done_o); end
      n_cmp++; if (chk_err_o !== pass[0] || chk_at_rise !== pass[0]) begin n_err++; $display("[TB] FAIL chk%0d_err: got %b/%b want %0d", pass, chk_err_o, chk_at_rise, pass); end
      n_cmp++; if (act_addr.size() != 2) begin n_err++; $display("[TB] FAIL chk%0d_writes: got %0d want 2", pass, act_addr.size()); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got time %0t want finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] bram_loader bench start");
    test_reset();
    test_illegal_len(1'b0);
    test_continuous();
    test_illegal_len(1'b1);
    test_backpressure();
    test_reload_ignored_start();
    test_reset_mid();
    test_random_loads();
`ifdef BRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
# bram_loader

Host-side write engine for the GAT accelerator's input BRAMs (H_col_idx, H_value, H_node_info, Weight, a). It accepts a valid/ready word stream and drives one BRAM's port-A write (din/ena/addra). It raises the level-sensitive `load_done` that the compute pipeline ANDs into its start condition. One instance is placed per input memory, on the far side of the top-level `*_BRAM_din/ena/addra/load_done` pins.

## Interface
Parameters:
- DATA_W, 16, BRAM word width (COL_IDX_WIDTH / VALUE_WIDTH / NODE_INFO_WIDTH / DATA_WIDTH per instance).
- ADDR_W, 10, BRAM address width.
- DEPTH, 1024, number of writable words; legal lengths are 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle load request; sampled only in IDLE or DONE.
- len_i  in  ADDR_W+1  number of data words to write; sampled with start_i.
- s_data_i  in  DATA_W  stream data.
- s_valid_i  in  1  stream data valid.
- s_ready_o  out  1  stream ready.
- bram_din_o  out  DATA_W  BRAM write data (to `*_BRAM_din`).
- bram_ena_o  out  1  BRAM write strobe (to `*_BRAM_ena`).
- bram_addra_o  out  ADDR_W  BRAM write address (to `*_BRAM_addra`).
- load_done_o  out  1  level: memory fully loaded (to `*_BRAM_load_done`).
- busy_o  out  1  high in LOAD or CHK.
- len_err_o  out  1  one-cycle pulse: start rejected for an illegal length.
- chk_err_o  out  1  sticky checksum mismatch; constant 0 without the macro.

## Operation
- States: IDLE, LOAD, CHK (only with the macro), DONE.
- IDLE/DONE + start_i:
  - len_i in 1..DEPTH: latch len, clear word counter and address to 0, clear load_done_o and chk_err_o, go to LOAD.
  - Otherwise: pulse len_err_o and stay in the current state. load_done_o is unchanged.
- LOAD:
  - s_ready_o=1.
  - Each handshake (s_valid_i & s_ready_o) writes s_data_i to the current address, then increments the address and counter.
  - On the handshake for word len-1: go to CHK (macro on) or DONE (macro off).
- CHK:
  - s_ready_o=1.
  - The next accepted word is a trailer. It is not written to BRAM.
  - If trailer ≠ running XOR of all written words, set chk_err_o.
  - Go to DONE.
- DONE:
  - load_done_o=1. It holds until the next accepted legal start_i.
- start_i in LOAD or CHK is ignored; no error is raised.
- Address never wraps, because len ≤ DEPTH is enforced at start.
- Counter width is ADDR_W+1 so that len=DEPTH is representable.

## Timing
- Reset values: s_ready_o=0, bram_din_o=0, bram_ena_o=0, bram_addra_o=0, load_done_o=0, busy_o=0, len_err_o=0, chk_err_o=0. State returns to IDLE.
- Reset asserted mid-load: the transfer is abandoned. Reloading requires a new start_i.
- All outputs are registered.
- Handshake at edge t produces bram_ena_o=1 with matching din and addra in cycle t+1. ena is a single-cycle strobe per word.
- s_ready_o rises the cycle after start_i is accepted, and falls the cycle after the final data word (macro off) or the trailer (macro on) is accepted.
- load_done_o:
  - Macro off: rises in the same cycle as the last bram_ena_o strobe.
  - Macro on: rises in the cycle after the trailer is accepted; chk_err_o is valid in that same cycle.
- Back-to-back writes run at 1 word/cycle. Gaps in s_valid_i produce gaps in bram_ena_o. The address advances only on a handshake.
- len_err_o is high for exactly the one cycle after the rejected start_i.

## Configuration
- Macro: BRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A DATA_W-bit XOR accumulator is updated on each written word and cleared on start.
  - The CHK state is compiled in and one trailer word is consumed per load.
  - chk_err_o is driven. load_done_o still asserts on a mismatch; consumers qualify it with chk_err_o.
- Undefined:
  - No accumulator, no CHK state, no trailer.
  - chk_err_o is tied 0.
  - The stream carries exactly len words.

## Test plan
- Continuous load: len=4, words 0x11,0x22,0x33,0x44 with s_valid_i held high → ena strobes at addr 0..3 with matching din on 4 consecutive cycles; load_done_o=1 with the addr-3 strobe (macro off); s_ready_o=0 afterward.
- Backpressure: len=3, s_valid_i pattern 1,0,0,1,0,1 → exactly 3 strobes at addr 0,1,2 aligned one cycle after each handshake; no strobe during gaps.
- Illegal length: start_i with len_i=0, then with len_i=DEPTH+1 → one-cycle len_err_o pulse each time; state and load_done_o unchanged; no BRAM writes.
- Reload and ignored start: full len=2 load, then start_i pulsed mid-load of a second len=2 load → load_done_o falls on the second accepted start; the mid-load start_i has no effect; second load writes addr 0,1.
- Reset mid-operation: rst_n low after 2 of 8 words → all outputs 0 immediately; after release, s_ready_o=0 until a new start_i.
- Checksum (macro on): len=2, data 0x00F0, 0x0F00, trailer 0x0FF0 → load_done_o=1, chk_err_o=0. Same load with trailer 0x0000 → load_done_o=1, chk_err_o=1, no BRAM write of the trailer.
